// File: rtl/noise_channel_gen2.sv
// Noise voice: LFSR stepped by a period timer, loudness from decay envelope or constant volume.
// All outputs are registered with 1-cycle latency; no backpressure, strobes are consumed as they arrive.
module noise_channel_gen2 #(
    parameter int LFSR_WIDTH   = 15,
    parameter int TAP_LONG     = 1,
    parameter int TAP_SHORT    = 6,
    parameter int PERIOD_WIDTH = 12,
    parameter int LEN_WIDTH    = 8,
    parameter int AMP_SCALE    = 11,
    parameter int OUT_WIDTH    = 9
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_tick_stb,
    input  logic                    i_env_stb,
    input  logic                    i_len_stb,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    input  logic                    i_mode,
    input  logic [3:0]              i_volume,
    input  logic                    i_const_vol,
    input  logic                    i_loop,
    input  logic                    i_enable,
    input  logic                    i_trigger,
    input  logic [LEN_WIDTH-1:0]    i_length,
    output logic [OUT_WIDTH-1:0]    o_output,
    output logic                    o_active,
    output logic                    o_shift_stb
);

    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
    logic                    env_start_q, env_start_d;
    logic [3:0]              env_div_q, env_div_d;
    logic [3:0]              decay_q, decay_d;
    logic [LEN_WIDTH-1:0]    length_q, length_d;
    logic [OUT_WIDTH-1:0]    output_q, output_d;
    logic                    active_q, active_d;
    logic                    shift_stb_q, shift_stb_d;
    logic                    shift;
    logic                    fb;
    logic [3:0]              vol;

    // Period timer and LFSR
    always_comb begin
        timer_d     = timer_q;
        lfsr_d      = lfsr_q;
        shift       = 1'b0;
        fb          = lfsr_q[0] ^ (i_mode ? lfsr_q[TAP_SHORT] : lfsr_q[TAP_LONG]);
        if (i_tick_stb) begin
            if (timer_q == '0) begin
                timer_d = i_period;
                shift   = 1'b1;
            end else begin
                timer_d = timer_q - PERIOD_WIDTH'(1);
            end
        end
        if (shift) begin
            // All-zero state would lock up; reseed with 1 instead.
            if (lfsr_q == '0) begin
                lfsr_d = LFSR_WIDTH'(1);
            end else begin
                lfsr_d = {fb, lfsr_q[LFSR_WIDTH-1:1]};
            end
        end
        shift_stb_d = shift;
    end

    // Decay envelope; a trigger arms the start flag for the following envelope clock
    always_comb begin
        env_start_d = env_start_q;
        env_div_d   = env_div_q;
        decay_d     = decay_q;
        if (i_env_stb) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                decay_d     = 4'd15;
                env_div_d   = i_volume;
            end else if (env_div_q == 4'd0) begin
                env_div_d = i_volume;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (i_loop) begin
                    decay_d = 4'd15;
                end
            end else begin
                env_div_d = env_div_q - 4'd1;
            end
        end
        if (i_trigger) begin
            env_start_d = 1'b1;
        end
    end

    // Length counter and output stage
    always_comb begin
        length_d = length_q;
        if (!i_enable) begin
            length_d = '0;
        end else if (i_trigger) begin
            length_d = i_length;
        end else if (i_len_stb && (length_q != '0) && !i_loop) begin
            length_d = length_q - LEN_WIDTH'(1);
        end

        vol      = i_const_vol ? i_volume : decay_q;
        output_d = '0;
        if (!lfsr_q[0] && (length_q != '0)) begin
            output_d = OUT_WIDTH'(vol) * OUT_WIDTH'(AMP_SCALE);
        end
        active_d = (length_q != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timer_q     <= '0;
            lfsr_q      <= LFSR_WIDTH'(1);
            env_start_q <= 1'b0;
            env_div_q   <= 4'd0;
            decay_q     <= 4'd0;
            length_q    <= '0;
            output_q    <= '0;
            active_q    <= 1'b0;
            shift_stb_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            env_start_q <= env_start_d;
            env_div_q   <= env_div_d;
            decay_q     <= decay_d;
            length_q    <= length_d;
            output_q    <= output_d;
            active_q    <= active_d;
            shift_stb_q <= shift_stb_d;
        end
    end

    assign o_output    = output_q;
    assign o_active    = active_q;
    assign o_shift_stb = shift_stb_q;

endmodule

// File: tb/tb_noise_channel_gen2.sv
// Bench for noise_channel_gen2: directed scenarios plus randomized traffic against an integer reference model.
module tb_noise_channel_gen2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_tick_stb = 1'b0;
    logic        i_env_stb = 1'b0;
    logic        i_len_stb = 1'b0;
    logic [11:0] i_period = '0;
    logic        i_mode = 1'b0;
    logic [3:0]  i_volume = '0;
    logic        i_const_vol = 1'b0;
    logic        i_loop = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_trigger = 1'b0;
    logic [7:0]  i_length = '0;
    logic [8:0]  o_output;
    logic        o_active;
    logic        o_shift_stb;

    int checks = 0;
    int failures = 0;

    // Reference model state, plain integers
    int m_timer = 0, m_lfsr = 1, m_start = 0, m_div = 0, m_decay = 0, m_len = 0;
    int m_out = 0, m_active = 0, m_shift = 0;

    always #5 i_clk = ~i_clk;

    noise_channel_gen2 dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_tick_stb  (i_tick_stb),
        .i_env_stb   (i_env_stb),
        .i_len_stb   (i_len_stb),
        .i_period    (i_period),
        .i_mode      (i_mode),
        .i_volume    (i_volume),
        .i_const_vol (i_const_vol),
        .i_loop      (i_loop),
        .i_enable    (i_enable),
        .i_trigger   (i_trigger),
        .i_length    (i_length),
        .o_output    (o_output),
        .o_active    (o_active),
        .o_shift_stb (o_shift_stb)
    );

    task automatic model_update();
        int vol, n_out, n_act, n_shift, n_timer, n_lfsr, n_start, n_div, n_decay, n_len, tap, fb;
        if (i_reset) begin
            m_timer = 0; m_lfsr = 1; m_start = 0; m_div = 0; m_decay = 0; m_len = 0;
            m_out = 0; m_active = 0; m_shift = 0;
        end else begin
            vol     = i_const_vol ? int'(i_volume) : m_decay;
            n_out   = ((m_lfsr % 2) == 0 && m_len != 0) ? vol * 11 : 0;
            n_act   = (m_len != 0) ? 1 : 0;
            n_timer = m_timer;
            n_lfsr  = m_lfsr;
            n_shift = 0;
            if (i_tick_stb) begin
                if (m_timer == 0) begin
                    n_timer = int'(i_period);
                    n_shift = 1;
                end else begin
                    n_timer = m_timer - 1;
                end
            end
            if (n_shift == 1) begin
                if (m_lfsr == 0) begin
                    n_lfsr = 1;
                end else begin
                    tap    = i_mode ? 6 : 1;
                    fb     = (m_lfsr ^ (m_lfsr >> tap)) & 1;
                    n_lfsr = (m_lfsr >> 1) + fb * 16384;
                end
            end
            n_start = m_start;
            n_div   = m_div;
            n_decay = m_decay;
            if (i_env_stb) begin
                if (m_start == 1) begin
                    n_start = 0;
                    n_decay = 15;
                    n_div   = int'(i_volume);
                end else if (m_div == 0) begin
                    n_div = int'(i_volume);
                    if (m_decay > 0) n_decay = m_decay - 1;
                    else if (i_loop) n_decay = 15;
                end else begin
                    n_div = m_div - 1;
                end
            end
            if (i_trigger) n_start = 1;
            if (!i_enable) n_len = 0;
            else if (i_trigger) n_len = int'(i_length);
            else if (i_len_stb && m_len > 0 && !i_loop) n_len = m_len - 1;
            else n_len = m_len;
            m_timer = n_timer; m_lfsr = n_lfsr; m_start = n_start; m_div = n_div;
            m_decay = n_decay; m_len = n_len; m_out = n_out; m_active = n_act; m_shift = n_shift;
        end
    endtask

    // Advance one clock: model sees the same inputs as the DUT, then sample 1 time unit later
    task automatic clk_step();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_tick_stb = 1'b0; i_env_stb = 1'b0; i_len_stb = 1'b0;
        i_period = '0; i_mode = 1'b0; i_volume = '0; i_const_vol = 1'b0; i_loop = 1'b0;
        i_enable = 1'b0; i_trigger = 1'b0; i_length = '0;
        clk_step();
        clk_step();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_output !== 9'd0) begin failures++; $display("FAIL reset_output got=%0d exp=0", o_output); end
        checks++;
        if (o_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", o_active); end
        checks++;
        if (o_shift_stb !== 1'b0) begin failures++; $display("FAIL reset_shift_stb got=%0b exp=0", o_shift_stb); end
        checks++;
        if (dut.lfsr_q !== 15'd1) begin failures++; $display("FAIL reset_lfsr got=%0d exp=1", dut.lfsr_q); end
    endtask

    task automatic test_long_lfsr();
        int first_ret = -1;
        int stb_cnt = 0;
        int bad = 0;
        do_reset();
        i_period = 12'd0; i_mode = 1'b0; i_tick_stb = 1'b1;
        for (int n = 1; n <= 32767; n++) begin
            clk_step();
            if (o_shift_stb === 1'b1) stb_cnt++;
            if (dut.lfsr_q === 15'd1 && first_ret < 0) first_ret = n;
            if (dut.lfsr_q !== 15'(m_lfsr)) bad++;
        end
        i_tick_stb = 1'b0;
        clk_step();
        if (o_shift_stb === 1'b1) stb_cnt++;
        checks++;
        if (first_ret != 32767) begin failures++; $display("FAIL long_lfsr_period got=%0d exp=32767", first_ret); end
        checks++;
        if (stb_cnt != 32767) begin failures++; $display("FAIL long_shift_count got=%0d exp=32767", stb_cnt); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL long_lfsr_model mismatches=%0d exp=0", bad); end
    endtask

    task automatic test_short_lfsr();
        int ret1 = -1, ret2 = -1;
        do_reset();
        i_period = 12'd0; i_mode = 1'b1; i_tick_stb = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            clk_step();
            if (dut.lfsr_q === 15'd1) begin
                if (ret1 < 0) ret1 = n;
                else if (ret2 < 0) ret2 = n;
            end
        end
        i_tick_stb = 1'b0;
        checks++;
        if (ret1 != 93) begin failures++; $display("FAIL short_lfsr_first got=%0d exp=93", ret1); end
        checks++;
        if (ret2 != 186) begin failures++; $display("FAIL short_lfsr_repeat got=%0d exp=186", ret2); end
    endtask

    task automatic test_period_change();
        int times[$];
        int chg_at = -1;
        int exp_gap[6] = '{5, 5, 5, 3, 3, 3};
        do_reset();
        i_period = 12'd4; i_tick_stb = 1'b1;
        for (int c = 0; c < 100 && times.size() < 7; c++) begin
            clk_step();
            if (o_shift_stb === 1'b1) times.push_back(c);
            if (times.size() == 3 && chg_at < 0) chg_at = c + 2;
            if (c == chg_at) i_period = 12'd2;
        end
        i_tick_stb = 1'b0;
        checks++;
        if (times.size() != 7) begin
            failures++; $display("FAIL period_strobes_timeout got=%0d exp=7", times.size());
        end else begin
            for (int g = 0; g < 6; g++) begin
                checks++;
                if (times[g+1] - times[g] != exp_gap[g]) begin
                    failures++;
                    $display("FAIL period_gap_%0d got=%0d exp=%0d", g, times[g+1] - times[g], exp_gap[g]);
                end
            end
        end
    endtask

    task automatic test_length_gate();
        int bad = 0, seen = 0, other = 0;
        do_reset();
        i_enable = 1'b1; i_const_vol = 1'b1; i_volume = 4'd15; i_loop = 1'b0;
        i_tick_stb = 1'b1; i_period = 12'd0; i_length = 8'd3; i_trigger = 1'b1;
        clk_step();
        i_trigger = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 6; c++) begin
                clk_step();
                if (o_output !== 9'(m_out)) bad++;
                if (o_output === 9'd165) seen++;
                else if (o_output !== 9'd0) other++;
            end
            i_len_stb = 1'b1;
            clk_step();
            i_len_stb = 1'b0;
        end
        checks++;
        if (o_active !== 1'b1) begin failures++; $display("FAIL len_active_lag got=%0b exp=1", o_active); end
        clk_step();
        checks++;
        if (o_active !== 1'b0) begin failures++; $display("FAIL len_active_fall got=%0b exp=0", o_active); end
        checks++;
        if (o_output !== 9'd0) begin failures++; $display("FAIL len_output_zero got=%0d exp=0", o_output); end
        checks++;
        if (seen == 0) begin failures++; $display("FAIL len_saw_165 got=%0d exp=>0", seen); end
        checks++;
        if (other != 0) begin failures++; $display("FAIL len_bad_level got=%0d exp=0", other); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL len_model mismatches=%0d exp=0", bad); end
        i_tick_stb = 1'b0;
    endtask

    task automatic test_envelope();
        int exp_d;
        int bad = 0;
        do_reset();
        i_tick_stb = 1'b1; i_period = 12'd0;
        clk_step();
        i_tick_stb = 1'b0;
        i_enable = 1'b1; i_loop = 1'b1; i_const_vol = 1'b0; i_volume = 4'd0;
        i_length = 8'd255; i_trigger = 1'b1;
        clk_step();
        i_trigger = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            if (k == 18) i_loop = 1'b0;
            if (k <= 17) exp_d = (32 - k) % 16;
            else exp_d = (15 - (k - 17) > 0) ? 15 - (k - 17) : 0;
            i_env_stb = 1'b1;
            clk_step();
            i_env_stb = 1'b0;
            clk_step();
            if (o_output !== 9'(exp_d * 11)) begin
                bad++;
                $display("FAIL env_step_%0d got=%0d exp=%0d", k, o_output, exp_d * 11);
            end
            clk_step();
            clk_step();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL env_sequence mismatches=%0d exp=0", bad); end
        i_trigger = 1'b1; i_env_stb = 1'b1;
        clk_step();
        i_trigger = 1'b0; i_env_stb = 1'b0;
        clk_step();
        checks++;
        if (o_output !== 9'd0) begin failures++; $display("FAIL env_same_cycle_trigger got=%0d exp=0", o_output); end
        clk_step();
        i_env_stb = 1'b1;
        clk_step();
        i_env_stb = 1'b0;
        clk_step();
        checks++;
        if (o_output !== 9'd165) begin failures++; $display("FAIL env_restart got=%0d exp=165", o_output); end
    endtask

    task automatic test_trigger_enable_reset();
        do_reset();
        i_enable = 1'b1; i_loop = 1'b0; i_length = 8'd37; i_trigger = 1'b1; i_len_stb = 1'b1;
        clk_step();
        i_trigger = 1'b0; i_len_stb = 1'b0;
        checks++;
        if (dut.length_q !== 8'd37) begin failures++; $display("FAIL trig_len_priority got=%0d exp=37", dut.length_q); end
        clk_step();
        checks++;
        if (o_active !== 1'b1) begin failures++; $display("FAIL trig_active got=%0b exp=1", o_active); end
        i_enable = 1'b0;
        clk_step();
        checks++;
        if (dut.length_q !== 8'd0) begin failures++; $display("FAIL disable_len got=%0d exp=0", dut.length_q); end
        clk_step();
        checks++;
        if (o_active !== 1'b0) begin failures++; $display("FAIL disable_active got=%0b exp=0", o_active); end

        i_enable = 1'b1; i_const_vol = 1'b0; i_volume = 4'd2; i_loop = 1'b1; i_length = 8'd100;
        i_trigger = 1'b1;
        clk_step();
        i_trigger = 1'b0; i_tick_stb = 1'b1; i_period = 12'd1;
        for (int c = 0; c < 30; c++) begin
            i_env_stb = (c % 3 == 0);
            clk_step();
        end
        i_reset = 1'b1; i_env_stb = 1'b1; i_len_stb = 1'b1; i_trigger = 1'b1;
        clk_step();
        i_reset = 1'b0; i_env_stb = 1'b0; i_len_stb = 1'b0; i_trigger = 1'b0; i_tick_stb = 1'b0;
        checks++;
        if (o_output !== 9'd0) begin failures++; $display("FAIL midreset_output got=%0d exp=0", o_output); end
        checks++;
        if (o_active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%0b exp=0", o_active); end
        checks++;
        if (o_shift_stb !== 1'b0) begin failures++; $display("FAIL midreset_shift got=%0b exp=0", o_shift_stb); end
        checks++;
        if (dut.lfsr_q !== 15'd1) begin failures++; $display("FAIL midreset_lfsr got=%0d exp=1", dut.lfsr_q); end
        checks++;
        if (dut.decay_q !== 4'd0) begin failures++; $display("FAIL midreset_decay got=%0d exp=0", dut.decay_q); end
    endtask

    task automatic test_random();
        int bad_out = 0, bad_act = 0, bad_stb = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_reset     = ($urandom_range(0, 199) == 0);
            i_tick_stb  = $urandom_range(0, 1) == 1;
            i_env_stb   = ($urandom_range(0, 7) == 0);
            i_len_stb   = ($urandom_range(0, 7) == 0);
            i_period    = 12'($urandom_range(0, 3));
            i_mode      = $urandom_range(0, 1) == 1;
            i_volume    = 4'($urandom_range(0, 15));
            i_const_vol = $urandom_range(0, 1) == 1;
            i_loop      = ($urandom_range(0, 3) == 0);
            i_enable    = ($urandom_range(0, 15) != 0);
            i_trigger   = ($urandom_range(0, 15) == 0);
            i_length    = 8'($urandom_range(0, 255));
            clk_step();
            if (o_output !== 9'(m_out)) bad_out++;
            if (o_active !== 1'(m_active)) bad_act++;
            if (o_shift_stb !== 1'(m_shift)) bad_stb++;
        end
        i_reset = 1'b0;
        checks++;
        if (bad_out != 0) begin failures++; $display("FAIL rand_output mismatches=%0d exp=0", bad_out); end
        checks++;
        if (bad_act != 0) begin failures++; $display("FAIL rand_active mismatches=%0d exp=0", bad_act); end
        checks++;
        if (bad_stb != 0) begin failures++; $display("FAIL rand_shift_stb mismatches=%0d exp=0", bad_stb); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_long_lfsr();
        test_short_lfsr();
        test_period_change();
        test_length_gate();
        test_envelope();
        test_trigger_enable_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
